cpu_instruction_dumper: RTL and testbench

Readback counterpart of the UART instruction loader: on request, pauses a halted CPU, reads a range of iRAM words and streams them to the UART transmitter as 3-byte packets, framed by the same start/end markers the loader accepts. The byte stream it emits can be looped straight back into the loader to reprogram iRAM identically. It sits between iRAM's external port and `uart_tx`, alongside the loader.

---
 rtl/cpu_loader_pkg.sv | 36 +++
 rtl/word_serializer.sv | 41 ++++
 rtl/cpu_instruction_dumper.sv | 125 ++++++++++++
 tb/tb_cpu_instruction_dumper.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_loader_pkg.sv
// rtl/cpu_loader_pkg.sv - markers, byte order and state encoding shared by the iRAM loader and dumper
package cpu_loader_pkg;

  localparam logic [23:0] MARKER_START     = 24'hFF0000;
  localparam logic [23:0] MARKER_END_RESET = 24'hFFFF00;
  localparam logic [23:0] MARKER_END_KEEP  = 24'hFFF000;

  localparam logic [1:0] BYTE_LAST = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_SEND,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    SRC_START,
    SRC_DATA,
    SRC_END
  } src_t;

  // Words travel least-significant byte first on the UART link.
  function automatic logic [7:0] word_byte(input logic [23:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      default: return w[23:16];
    endcase
  endfunction

  function automatic logic is_marker(input logic [23:0] w);
    return (w == MARKER_START) || (w == MARKER_END_RESET) || (w == MARKER_END_KEEP);
  endfunction

endpackage

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - loads a 24-bit word and emits its three bytes over a valid/ready handshake
module word_serializer
  import cpu_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [23:0] load_word,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        done
);

  logic [23:0] word;
  logic [1:0]  byte_cnt;

  // A load wins over a handshake so the next word can follow the last byte back to back.
  always_ff @(posedge clk) begin
    if (rst) begin
      word     <= 24'h000000;
      byte_cnt <= 2'd0;
      tx_valid <= 1'b0;
    end else if (load) begin
      word     <= load_word;
      byte_cnt <= 2'd0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (byte_cnt == BYTE_LAST) begin
        byte_cnt <= 2'd0;
        tx_valid <= 1'b0;
      end else begin
        byte_cnt <= byte_cnt + 2'd1;
      end
    end
  end

  assign done    = tx_valid && tx_ready && (byte_cnt == BYTE_LAST);
  assign tx_data = tx_valid ? word_byte(word, byte_cnt) : 8'h00;

endmodule

// File: rtl/cpu_instruction_dumper.sv
// rtl/cpu_instruction_dumper.sv - pauses a halted CPU and streams an iRAM range to the UART as loader packets
module cpu_instruction_dumper
  import cpu_loader_pkg::*;
#(
  parameter logic [7:0] FIRST_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dump_req,
  input  logic        HALT_flag,
  input  logic [7:0]  dump_last,
  input  logic        data_ack,
  input  logic [23:0] iRAM_data_out,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        iRAM_read_enable,
  output logic [7:0]  extern_iRAM_addr,
  output logic        cpu_paused,
  output logic        busy,
  output logic        marker_collision
);

  state_t      state, state_n;
  src_t        src, src_n;
  logic [7:0]  addr, addr_n;
  logic [7:0]  last_addr, last_addr_n;
  logic        paused_n, collision_n;
  logic        ser_load, ser_done;
  logic [23:0] ser_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      src              <= SRC_START;
      addr             <= FIRST_ADDR;
      last_addr        <= FIRST_ADDR;
      cpu_paused       <= 1'b0;
      marker_collision <= 1'b0;
    end else begin
      state            <= state_n;
      src              <= src_n;
      addr             <= addr_n;
      last_addr        <= last_addr_n;
      cpu_paused       <= paused_n;
      marker_collision <= collision_n;
    end
  end

  always_comb begin
    state_n     = state;
    src_n       = src;
    addr_n      = addr;
    last_addr_n = last_addr;
    paused_n    = cpu_paused;
    collision_n = marker_collision;
    ser_load    = 1'b0;
    ser_word    = MARKER_START;
    case (state)
      ST_IDLE: begin
        if (dump_req && HALT_flag) begin
          ser_load    = 1'b1;
          ser_word    = MARKER_START;
          src_n       = SRC_START;
          last_addr_n = dump_last;
          paused_n    = 1'b1;
          collision_n = 1'b0;
          state_n     = ST_SEND;
        end
      end
      ST_READ: begin
        if (data_ack) begin
          ser_load = 1'b1;
          ser_word = iRAM_data_out;
          src_n    = SRC_DATA;
          if (is_marker(iRAM_data_out)) collision_n = 1'b1;
          state_n  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (ser_done) begin
          case (src)
            SRC_START: begin
              addr_n  = FIRST_ADDR;
              state_n = ST_READ;
            end
            SRC_DATA: begin
              // >= rather than == keeps a dump_last below FIRST_ADDR to one word and never wraps.
              if (addr >= last_addr) begin
                ser_load = 1'b1;
                ser_word = MARKER_END_KEEP;
                src_n    = SRC_END;
              end else begin
                addr_n  = addr + 8'd1;
                state_n = ST_READ;
              end
            end
            default: state_n = ST_FINISH;
          endcase
        end
      end
      default: begin
        paused_n = 1'b0;
        addr_n   = FIRST_ADDR;
        state_n  = ST_IDLE;
      end
    endcase
  end

  word_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .load_word (ser_word),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .done      (ser_done)
  );

  assign busy             = (state != ST_IDLE);
  assign iRAM_read_enable = (state == ST_READ);
  assign extern_iRAM_addr = addr;

endmodule

// File: tb/tb_cpu_instruction_dumper.sv
// tb/tb_cpu_instruction_dumper.sv - table-driven and directed checks of cpu_instruction_dumper
module tb_cpu_instruction_dumper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dump_req = 1'b0;
  logic        HALT_flag = 1'b0;
  logic [7:0]  dump_last = 8'h00;
  logic        data_ack = 1'b0;
  logic [23:0] iRAM_data_out = 24'h0;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        iRAM_read_enable;
  logic [7:0]  extern_iRAM_addr;
  logic        cpu_paused;
  logic        busy;
  logic        marker_collision;

  always #5 clk = ~clk;

  cpu_instruction_dumper dut (
    .clk              (clk),
    .rst              (rst),
    .dump_req         (dump_req),
    .HALT_flag        (HALT_flag),
    .dump_last        (dump_last),
    .data_ack         (data_ack),
    .iRAM_data_out    (iRAM_data_out),
    .tx_ready         (tx_ready),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .iRAM_read_enable (iRAM_read_enable),
    .extern_iRAM_addr (extern_iRAM_addr),
    .cpu_paused       (cpu_paused),
    .busy             (busy),
    .marker_collision (marker_collision)
  );

  typedef struct {
    string       name;
    logic [7:0]  last;
    logic [23:0] w0;
    logic [23:0] w1;
    int          rmode;
    int          exp_bytes;
    logic        exp_coll;
  } vec_t;

  logic [23:0] mem [256];
  logic [7:0]  byte_q [$];
  logic [7:0]  exp_q [$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          fall_cyc = 0;
  int          stab_err = 0;
  int          valid_cnt = 0;
  int          rmode = 0;
  int          last_rd = -1;
  logic        hold_pending = 1'b0;
  logic [7:0]  hold_data = 8'h00;
  logic        paused_prev = 1'b0;

  always @(posedge clk) cyc++;

  // iRAM responder, UART sink and handshake monitor, all on the falling edge
  always @(negedge clk) begin
    if (iRAM_read_enable && !data_ack) begin
      data_ack      = 1'b1;
      iRAM_data_out = mem[extern_iRAM_addr];
      last_rd       = int'(extern_iRAM_addr);
    end else begin
      data_ack = 1'b0;
    end
    if (hold_pending && (!tx_valid || tx_data != hold_data)) stab_err++;
    case (rmode)
      0:       tx_ready = 1'b0;
      1:       tx_ready = 1'b1;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
    if (tx_valid) valid_cnt++;
    if (tx_valid && tx_ready && !rst) begin
      byte_q.push_back(tx_data);
      acc_cyc = cyc;
    end
    hold_pending = tx_valid && !tx_ready && !rst;
    hold_data    = tx_data;
    if (paused_prev && !cpu_paused) fall_cyc = cyc;
    paused_prev = cpu_paused;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic set_mem_default();
    for (int i = 0; i < 256; i++) mem[i] = {8'h5A ^ i[7:0], i[7:0], ~i[7:0]};
  endtask

  task automatic build_exp(input logic [7:0] last);
    logic [23:0] w;
    exp_q.delete();
    exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'hFF);
    for (int a = 0; a <= int'(last); a++) begin
      w = mem[a];
      exp_q.push_back(w[7:0]); exp_q.push_back(w[15:8]); exp_q.push_back(w[23:16]);
    end
    exp_q.push_back(8'h00); exp_q.push_back(8'hF0); exp_q.push_back(8'hFF);
  endtask

  // Issues a one-cycle request and checks the first byte appears right after acceptance.
  task automatic start_dump(input string name, input logic [7:0] last);
    dump_last = last;
    dump_req  = 1'b1;
    HALT_flag = 1'b1;
    tick();
    dump_req  = 1'b0;
    HALT_flag = 1'b0;
    check({name, " first tx_valid"}, 32'(tx_valid), 32'd1);
    check({name, " first tx_data"}, 32'(tx_data), 32'h00);
    check({name, " paused at accept"}, 32'(cpu_paused), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 5000) begin
      tick();
      n++;
    end
    check({name, " completion timeout"}, 32'(busy), 32'd0);
    tick();
  endtask

  task automatic check_stream(input string name);
    int bad = 0;
    check({name, " byte count vs model"}, 32'(byte_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++)
      if (byte_q[i] !== exp_q[i]) bad++;
    check({name, " byte mismatches"}, 32'(bad), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    set_mem_default();
    mem[0] = v.w0;
    mem[1] = v.w1;
    rmode  = v.rmode;
    byte_q.delete();
    stab_err = 0;
    last_rd  = -1;
    build_exp(v.last);
    start_dump(v.name, v.last);
    wait_idle(v.name);
    check({v.name, " byte count"}, 32'(byte_q.size()), 32'(v.exp_bytes));
    check_stream(v.name);
    check({v.name, " marker_collision"}, 32'(marker_collision), 32'(v.exp_coll));
    check({v.name, " cpu_paused at end"}, 32'(cpu_paused), 32'd0);
    check({v.name, " tx_data stable while stalled"}, 32'(stab_err), 32'd0);
    check({v.name, " last read address"}, 32'(last_rd), 32'(v.last));
    check({v.name, " paused fall latency"}, 32'(fall_cyc - acc_cyc), 32'd2);
  endtask

  vec_t vecs [6];
  logic [7:0] lit [12];

  initial begin
    vecs[0] = '{"two_words",      8'h01, 24'h123456, 24'hABCDEF, 1, 12,  1'b0};
    vecs[1] = '{"two_words_rand", 8'h01, 24'h123456, 24'hABCDEF, 2, 12,  1'b0};
    vecs[2] = '{"end_keep_data",  8'h00, 24'hFFF000, 24'h000001, 1, 9,   1'b1};
    vecs[3] = '{"start_data_rnd", 8'h00, 24'hFF0000, 24'h000001, 2, 9,   1'b1};
    vecs[4] = '{"three_words",    8'h02, 24'h00FFFF, 24'hFFFF01, 2, 15,  1'b0};
    vecs[5] = '{"full_range",     8'hFF, 24'h010203, 24'h040506, 1, 774, 1'b0};
    lit = '{8'h00, 8'h00, 8'hFF, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hCD, 8'hAB, 8'h00, 8'hF0, 8'hFF};
    set_mem_default();

    rst = 1'b1;
    repeat (3) tick();
    check("reset tx_valid", 32'(tx_valid), 32'd0);
    check("reset tx_data", 32'(tx_data), 32'h00);
    check("reset read_enable", 32'(iRAM_read_enable), 32'd0);
    check("reset addr", 32'(extern_iRAM_addr), 32'h00);
    check("reset cpu_paused", 32'(cpu_paused), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset marker_collision", 32'(marker_collision), 32'd0);
    rst = 1'b0;
    tick();

    // Request without a halted CPU must be ignored.
    valid_cnt = 0;
    dump_req  = 1'b1;
    HALT_flag = 1'b0;
    repeat (6) tick();
    dump_req = 1'b0;
    check("no halt tx_valid cycles", 32'(valid_cnt), 32'd0);
    check("no halt cpu_paused", 32'(cpu_paused), 32'd0);
    check("no halt busy", 32'(busy), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        int bad = 0;
        for (int k = 0; k < 12 && k < byte_q.size(); k++)
          if (byte_q[k] !== lit[k]) bad++;
        check("two_words literal stream", 32'(bad), 32'd0);
      end
    end

    // Reset after the fifth byte aborts with no further traffic; a new request restarts cleanly.
    set_mem_default();
    rmode = 1;
    byte_q.delete();
    start_dump("mid_reset", 8'h01);
    begin
      int n = 0;
      while (byte_q.size() < 5 && n < 200) begin
        tick();
        n++;
      end
    end
    check("mid_reset reached 5 bytes", 32'(byte_q.size()), 32'd5);
    rmode = 0;
    tick();
    rst = 1'b1;
    tick();
    check("mid_reset tx_valid", 32'(tx_valid), 32'd0);
    check("mid_reset tx_data", 32'(tx_data), 32'h00);
    check("mid_reset read_enable", 32'(iRAM_read_enable), 32'd0);
    check("mid_reset addr", 32'(extern_iRAM_addr), 32'h00);
    check("mid_reset cpu_paused", 32'(cpu_paused), 32'd0);
    check("mid_reset busy", 32'(busy), 32'd0);
    rst = 1'b0;
    valid_cnt = 0;
    rmode = 1;
    repeat (5) tick();
    check("mid_reset no tx_valid after", 32'(valid_cnt), 32'd0);
    check("mid_reset no further bytes", 32'(byte_q.size()), 32'd5);
    byte_q.delete();
    build_exp(8'h01);
    start_dump("restart", 8'h01);
    wait_idle("restart");
    check_stream("restart");

    // Request held across FINISH restarts one cycle after IDLE.
    byte_q.delete();
    rmode     = 1;
    dump_last = 8'h00;
    dump_req  = 1'b1;
    HALT_flag = 1'b1;
    begin
      int n = 0;
      while (byte_q.size() < 9 && n < 200) begin
        tick();
        n++;
      end
    end
    check("held_req nine bytes", 32'(byte_q.size()), 32'd9);
    tick();
    check("held_req finish busy", 32'(busy), 32'd1);
    tick();
    check("held_req idle busy", 32'(busy), 32'd0);
    check("held_req idle paused", 32'(cpu_paused), 32'd0);
    tick();
    check("held_req restart busy", 32'(busy), 32'd1);
    check("held_req restart tx_valid", 32'(tx_valid), 32'd1);
    dump_req  = 1'b0;
    HALT_flag = 1'b0;
    wait_idle("held_req");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
